// File: rtl/irq_sequencer_if.sv
// -----------------------------------------------------------------------------
// irq_sequencer_if
//
// Purpose: groups every signal between the interrupt sequencer and the control
// unit / status register.
//
// Handshake semantics: there is no valid/ready pair here. `boundary` qualifies
// `irq` and `rti_req` for exactly the cycle it is high. Every ld_* output is a
// one-cycle load strobe, and its data (status_out, vector) is valid in that
// same cycle. irq_ack and rti_err are one-cycle pulses.
//
// Signals:
//   irq        [N_IRQ] level interrupt requests, bit 0 highest priority
//   status_in  [6]     current status word {mode, imask, alu_status[3:0]}
//   boundary           instruction boundary
//   rti_req            return-from-interrupt request (qualified by boundary)
//   busy               sequencer active
//   status_out [6]     restore data, with ld_status
//   imask_out/ld_imask imask value and load strobe for the entry write
//   mode_out/ld_mode   mode value and load strobe for the entry write
//   vector     [16]    vector address, with ld_pc
//   irq_ack    [N_IRQ] one-hot acknowledge of the taken line
//   rti_err            RTI issued with an empty shadow stack
//   ovf                sticky: an entry was blocked by a full stack
//   dbg_state  [3]     FSM state, for checkers
//   dbg_sp     [8]     shadow-stack pointer, for checkers
//
// Modports: slave = the sequencer, master = the control-unit side.
// -----------------------------------------------------------------------------
interface irq_sequencer_if #(
    parameter int N_IRQ = 4
);
    logic [N_IRQ-1:0] irq;
    logic [5:0]       status_in;
    logic             boundary;
    logic             rti_req;
    logic             busy;
    logic [5:0]       status_out;
    logic             ld_status;
    logic             imask_out;
    logic             ld_imask;
    logic             mode_out;
    logic             ld_mode;
    logic [15:0]      vector;
    logic             ld_pc;
    logic [N_IRQ-1:0] irq_ack;
    logic             rti_err;
    logic             ovf;
    logic [2:0]       dbg_state;
    logic [7:0]       dbg_sp;

    modport slave (
        input  irq, status_in, boundary, rti_req,
        output busy, status_out, ld_status, imask_out, ld_imask,
               mode_out, ld_mode, vector, ld_pc, irq_ack, rti_err, ovf,
               dbg_state, dbg_sp
    );

    modport master (
        output irq, status_in, boundary, rti_req,
        input  busy, status_out, ld_status, imask_out, ld_imask,
               mode_out, ld_mode, vector, ld_pc, irq_ack, rti_err, ovf,
               dbg_state, dbg_sp
    );
endinterface

// File: rtl/irq_sequencer.sv
// -----------------------------------------------------------------------------
// irq_sequencer
//
// Purpose: interrupt entry/return sequencer for the CPU status register.
// At an instruction boundary it either services an RTI (restoring the last
// saved status word) or takes the highest-priority pending IRQ. Taking an IRQ
// saves the status word to a shadow stack, clears imask, forces supervisor
// mode and loads the vector into the PC.
//
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous, active-low reset
//   bus  irq_sequencer_if.slave (see the interface file for the signal list)
//
// Configuration:
//   IRQ_NEST_EN defined   : shadow stack of STACK_DEPTH entries (nesting)
//   IRQ_NEST_EN undefined : single shadow register, STACK_DEPTH ignored
//
// Sequence: IDLE -> SAVE -> MASK -> VECTOR -> IDLE for entry,
//           IDLE -> RESTORE -> IDLE for return.
// All outputs are registered: each strobe is computed on the transition into
// the state it belongs to, so it is high for exactly that state's cycle.
// -----------------------------------------------------------------------------
module irq_sequencer #(
    parameter int          N_IRQ           = 4,
    parameter logic [15:0] VEC_BASE        = 16'h0010,
    parameter int          STACK_DEPTH     = 4,
    parameter logic        SUPERVISOR_MODE = 1'b1
) (
    input logic            clk,
    input logic            rst,
    irq_sequencer_if.slave bus
);

`ifdef IRQ_NEST_EN
    localparam int DEPTH = STACK_DEPTH;
`else
    // One shadow register; STACK_DEPTH has no effect in this build.
    localparam int DEPTH = (STACK_DEPTH > 0) ? 1 : 1;
`endif

    localparam int SPW  = $clog2(DEPTH + 1);                 // sp counts 0..DEPTH
    localparam int IW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;   // stack index width
    localparam int IDXW = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;   // winner index width

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SAVE    = 3'd1,
        ST_MASK    = 3'd2,
        ST_VECTOR  = 3'd3,
        ST_RESTORE = 3'd4
    } state_t;

    state_t           state_q,      state_d;
    logic [SPW-1:0]   sp_q,         sp_d;
    logic [IDXW-1:0]  idx_q,        idx_d;
    logic [5:0]       stack_q [2**IW];
    logic [5:0]       stack_d [2**IW];
    logic             busy_q,       busy_d;
    logic [5:0]       status_out_q, status_out_d;
    logic             ld_status_q,  ld_status_d;
    logic             ld_mask_q,    ld_mask_d;   // drives ld_imask and ld_mode
    logic [15:0]      vector_q,     vector_d;
    logic             ld_pc_q,      ld_pc_d;
    logic [N_IRQ-1:0] irq_ack_q,    irq_ack_d;
    logic             rti_err_q,    rti_err_d;
    logic             ovf_q,        ovf_d;

    logic             full;
    logic             want;          // an IRQ would be taken if there were room
    logic [IDXW-1:0]  win;
    logic [SPW-1:0]   sp_m1;

    assign full  = (sp_q == SPW'(DEPTH));
    assign want  = bus.boundary && bus.status_in[4] && (|bus.irq);
    assign sp_m1 = sp_q - 1'b1;

    // Lowest set bit wins: scan from the top so the lowest index is written last.
    always_comb begin
        win = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (bus.irq[i]) begin
                win = IDXW'(i);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        sp_d         = sp_q;
        idx_d        = idx_q;
        stack_d      = stack_q;
        status_out_d = '0;
        ld_status_d  = 1'b0;
        ld_mask_d    = 1'b0;
        vector_d     = '0;
        ld_pc_d      = 1'b0;
        irq_ack_d    = '0;
        rti_err_d    = 1'b0;
        ovf_d        = ovf_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.boundary && bus.rti_req) begin
                    // RTI has priority over any pending IRQ.
                    state_d = ST_RESTORE;
                    if (sp_q != '0) begin
                        status_out_d = stack_q[sp_m1[IW-1:0]];
                        ld_status_d  = 1'b1;
                        sp_d         = sp_m1;
                    end else begin
                        rti_err_d = 1'b1;
                    end
                end else if (want && !full) begin
                    state_d = ST_SAVE;
                    idx_d   = win;
                end else if (want) begin
                    ovf_d = 1'b1;
                end
            end
            ST_SAVE: begin
                // status_in still holds the pre-entry word in this cycle.
                stack_d[sp_q[IW-1:0]] = bus.status_in;
                sp_d      = sp_q + 1'b1;
                ld_mask_d = 1'b1;
                state_d   = ST_MASK;
            end
            ST_MASK: begin
                ld_pc_d  = 1'b1;
                vector_d = VEC_BASE + (16'(idx_q) << 1);
                for (int i = 0; i < N_IRQ; i++) begin
                    irq_ack_d[i] = (IDXW'(i) == idx_q);
                end
                state_d = ST_VECTOR;
            end
            ST_VECTOR:  state_d = ST_IDLE;
            ST_RESTORE: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    assign busy_d = (state_d != ST_IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            sp_q         <= '0;
            idx_q        <= '0;
            for (int i = 0; i < 2**IW; i++) begin
                stack_q[i] <= '0;
            end
            busy_q       <= 1'b0;
            status_out_q <= '0;
            ld_status_q  <= 1'b0;
            ld_mask_q    <= 1'b0;
            vector_q     <= '0;
            ld_pc_q      <= 1'b0;
            irq_ack_q    <= '0;
            rti_err_q    <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            sp_q         <= sp_d;
            idx_q        <= idx_d;
            stack_q      <= stack_d;
            busy_q       <= busy_d;
            status_out_q <= status_out_d;
            ld_status_q  <= ld_status_d;
            ld_mask_q    <= ld_mask_d;
            vector_q     <= vector_d;
            ld_pc_q      <= ld_pc_d;
            irq_ack_q    <= irq_ack_d;
            rti_err_q    <= rti_err_d;
            ovf_q        <= ovf_d;
        end
    end

    assign bus.busy       = busy_q;
    assign bus.status_out = status_out_q;
    assign bus.ld_status  = ld_status_q;
    assign bus.imask_out  = 1'b0;
    assign bus.ld_imask   = ld_mask_q;
    assign bus.mode_out   = SUPERVISOR_MODE;
    assign bus.ld_mode    = ld_mask_q;
    assign bus.vector     = vector_q;
    assign bus.ld_pc      = ld_pc_q;
    assign bus.irq_ack    = irq_ack_q;
    assign bus.rti_err    = rti_err_q;
    assign bus.ovf        = ovf_q;
    assign bus.dbg_state  = state_q;
    assign bus.dbg_sp     = 8'(sp_q);

endmodule
